// File: rtl/fht_frame_sched_pkg.sv
// Shared constants for the FHT frame scheduler: FSM state codes, RAM owner
// codes and a width-parameterised bit-reverse helper.
// Pure declarations; no latency or flow control of its own.
package fht_frame_sched_pkg;

  // Scheduler FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_KICK   = 3'd2;
  localparam logic [2:0] ST_ARM    = 3'd3;
  localparam logic [2:0] ST_RUN    = 3'd4;
  localparam logic [2:0] ST_UNLOAD = 3'd5;
  localparam logic [2:0] ST_DRAIN  = 3'd6;

  // RAM mux owner codes
  localparam logic [1:0] OWN_LOADER   = 2'd0;
  localparam logic [1:0] OWN_CORE     = 2'd1;
  localparam logic [1:0] OWN_UNLOADER = 2'd2;
  localparam logic [1:0] OWN_NONE     = 2'd3;

  // Reverse the low w bits of v (w <= 32); bits above w come out zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    t = v;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        r = {r[30:0], t[0]};
        t = t >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fht_frame_sched_out_skid.sv
// fht_out_skid: 2-entry valid/ready output buffer for unloaded samples (+last flag).
// Latency: push visible on out_vld the cycle after in_vld; out_vld is a pure flop output.
// Backpressure: free=1 only if a read issued now still has a slot once the
//   sample already in flight (in_vld) lands, net of this cycle's pop.
// Ports: clk/rst (sync, active-high), in_vld/in_dat (RAM return),
//   out_vld/out_dat/out_rdy (downstream), free (read-issue gate), empty.
module fht_out_skid #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy,
  output logic         free,
  output logic         empty
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic         pop;
  logic [2:0]   occ;

  assign out_vld = (cnt_q != 2'd0);
  assign out_dat = slot0_q;
  assign pop     = out_vld & out_rdy;
  assign empty   = (cnt_q == 2'd0);

  // Occupancy after this cycle, including the sample landing now.
  assign occ  = 3'(cnt_q) + 3'(in_vld) - 3'(pop);
  assign free = (occ < 3'd2);

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q + 2'(in_vld) - 2'(pop);
    if (pop) begin
      slot0_d = slot1_q;
    end
    // New sample goes to the first slot left free after the pop.
    if (in_vld) begin
      if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop)) begin
        slot0_d = in_dat;
      end else begin
        slot1_d = in_dat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

endmodule

// File: rtl/fht_frame_sched.sv
// Frame scheduler: owns the 4-bank FHT RAM, sequences load -> core -> unload, one frame at a time.
// Latency: write same cycle as accept; start 1 cycle after last sample; first output 2 cycles into unload.
// Backpressure: oREADY only in LOAD; unload reads stall when the 2-entry output buffer has no free slot.
// Ports: iCLK/iRESET (sync, active-high); loader iVALID/iDATA/oREADY; core oSTART/iCORE_RDY/iRESULT_SEL;
//   RAM oOWNER/oBANK/oADDR/oWE/oWDATA/oRD_SET/iRDATA; output oVALID/oDATA/oLAST/iREADY; oBUSY/oDONE.
// Build option: define FHT_SCHED_BITREV_EN to store loaded samples at bit-reversed positions.
module fht_frame_sched
  import fht_frame_sched_pkg::*;
#(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iVALID,
  input  logic [D_BIT-1:0] iDATA,
  output logic             oREADY,
  output logic             oSTART,
  input  logic             iCORE_RDY,
  input  logic             iRESULT_SEL,
  output logic [1:0]       oOWNER,
  output logic [1:0]       oBANK,
  output logic [A_BIT-1:0] oADDR,
  output logic             oWE,
  output logic [D_BIT-1:0] oWDATA,
  output logic             oRD_SET,
  input  logic [D_BIT-1:0] iRDATA,
  output logic             oVALID,
  output logic [D_BIT-1:0] oDATA,
  output logic             oLAST,
  input  logic             iREADY,
  output logic             oBUSY,
  output logic             oDONE
);

  localparam int IW = A_BIT + 2;
  localparam logic [IW-1:0] LAST_IDX = '1;

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] k_q, k_d;
  logic [IW-1:0] j_q, j_d;
  logic          rd_set_q, rd_set_d;
  logic          pend_q, pend_d;          // RAM read issued last cycle, data on iRDATA now
  logic          pend_last_q, pend_last_d;

  logic          rd_issue;
  logic          sk_free, sk_empty, sk_vld;
  logic [D_BIT:0] sk_dat;
  logic [IW-1:0] wr_pos;

`ifdef FHT_SCHED_BITREV_EN
  assign wr_pos = IW'(bitrev(32'(k_q), IW));
`else
  assign wr_pos = k_q;
`endif

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    j_d         = j_q;
    rd_set_d    = rd_set_q;
    oOWNER      = OWN_NONE;
    oREADY      = 1'b0;
    oSTART      = 1'b0;
    oWE         = 1'b0;
    oWDATA      = '0;
    oBANK       = 2'd0;
    oADDR       = '0;
    oDONE       = 1'b0;
    rd_issue    = 1'b0;
    pend_last_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The waking sample is not accepted here; it is taken in LOAD.
        if (iVALID) begin
          state_d = ST_LOAD;
          k_d     = '0;
        end
      end
      ST_LOAD: begin
        oOWNER = OWN_LOADER;
        oREADY = 1'b1;
        oBANK  = wr_pos[1:0];
        oADDR  = wr_pos[IW-1:2];
        if (iVALID) begin
          oWE    = 1'b1;
          oWDATA = iDATA;
          k_d    = k_q + 1'b1;
          if (k_q == LAST_IDX) state_d = ST_KICK;
        end
      end
      ST_KICK: begin
        oOWNER  = OWN_CORE;
        oSTART  = 1'b1;
        state_d = ST_ARM;
      end
      ST_ARM: begin
        // Core may still show idle for a while after the start pulse.
        oOWNER = OWN_CORE;
        if (!iCORE_RDY) state_d = ST_RUN;
      end
      ST_RUN: begin
        oOWNER = OWN_CORE;
        if (iCORE_RDY) begin
          rd_set_d = iRESULT_SEL;
          j_d      = '0;
          state_d  = ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        oOWNER   = OWN_UNLOADER;
        oBANK    = j_q[1:0];
        oADDR    = j_q[IW-1:2];
        rd_issue = sk_free;
        if (sk_free) begin
          j_d         = j_q + 1'b1;
          pend_last_d = (j_q == LAST_IDX);
          if (j_q == LAST_IDX) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        oOWNER = OWN_UNLOADER;
        if (sk_empty && !pend_q) begin
          oDONE   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pend_d = rd_issue;
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      j_q         <= '0;
      rd_set_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      j_q         <= j_d;
      rd_set_q    <= rd_set_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
    end
  end

  assign oBUSY   = (state_q != ST_IDLE);
  assign oRD_SET = rd_set_q;

  fht_out_skid #(
    .W(D_BIT + 1)
  ) u_skid (
    .clk     (iCLK),
    .rst     (iRESET),
    .in_vld  (pend_q),
    .in_dat  ({pend_last_q, iRDATA}),
    .out_vld (sk_vld),
    .out_dat (sk_dat),
    .out_rdy (iREADY),
    .free    (sk_free),
    .empty   (sk_empty)
  );

  assign oVALID = sk_vld;
  assign oDATA  = sk_dat[D_BIT-1:0];
  assign oLAST  = sk_dat[D_BIT];

endmodule

// File: tb/tb_fht_frame_sched.sv
// Self-checking bench for fht_frame_sched with A_BIT=2 (N=16): bench-side RAM and
// core models, random stimulus, and a per-cycle comparison against a frame-level model.
module tb_fht_frame_sched;
  localparam int A_BIT = 2;
  localparam int D_BIT = 16;
  localparam int N     = 16;

  logic             iCLK, iRESET, iVALID, iCORE_RDY, iRESULT_SEL, iREADY;
  logic [D_BIT-1:0] iDATA, iRDATA;
  logic             oREADY, oSTART, oWE, oRD_SET, oVALID, oLAST, oBUSY, oDONE;
  logic [1:0]       oOWNER, oBANK;
  logic [A_BIT-1:0] oADDR;
  logic [D_BIT-1:0] oWDATA, oDATA;

  fht_frame_sched #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iVALID(iVALID), .iDATA(iDATA), .oREADY(oREADY),
    .oSTART(oSTART), .iCORE_RDY(iCORE_RDY), .iRESULT_SEL(iRESULT_SEL),
    .oOWNER(oOWNER), .oBANK(oBANK), .oADDR(oADDR), .oWE(oWE), .oWDATA(oWDATA),
    .oRD_SET(oRD_SET), .iRDATA(iRDATA), .oVALID(oVALID), .oDATA(oDATA),
    .oLAST(oLAST), .iREADY(iREADY), .oBUSY(oBUSY), .oDONE(oDONE)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Where the loader must place sample k (linear position; bank = p%4, addr = p/4).
  function automatic int perm(input int k);
`ifdef FHT_SCHED_BITREV_EN
    int r = 0;
    for (int b = 0; b < 4; b++) if ((k & (1 << b)) != 0) r |= 1 << (3 - b);
    return r;
`else
    return k;
`endif
  endfunction

  // Stand-in transform: which result set was chosen is visible in the data.
  function automatic logic [15:0] xform(input logic sel, input logic [15:0] x);
    return sel ? (x ^ 16'h5A5A) : (x + 16'h0101);
  endfunction

  // Model state
  logic [15:0] acc[$];
  logic [15:0] ram[2][4][4];
  logic [15:0] exp_out[N];
  logic [15:0] rd_next, prev_dat;
  int          wr_bank[N], wr_addr[N];
  int          n_out, last_count;
  bit          start_due, done_due, prev_stall, core_busy, rd_sel_exp, chk_en;
  bit          frame_sel, rdy_rand, tgl_sel;

  // Compare process
  always @(negedge iCLK) begin : compare
    int k, p;
    rd_next = ram[oRD_SET][oBANK][oADDR];
    if (iRESET) begin
      acc.delete();
      start_due  = 0;
      done_due   = 0;
      n_out      = 0;
      prev_stall = 0;
    end else if (chk_en) begin
      chk("start_pulse", oSTART, start_due);
      start_due = 0;
      chk("done_pulse", oDONE, done_due);
      done_due = 0;
      if (oDONE) begin
        last_count = n_out;
        acc.delete();
        n_out = 0;
      end
      chk("we_vs_accept", oWE, iVALID && oREADY);
      if (oWE) begin
        k = acc.size();
        if (k >= N) begin
          chk("extra_write", k, N - 1);
        end else begin
          p = perm(k);
          chk("wr_bank", oBANK, p % 4);
          chk("wr_addr", oADDR, p / 4);
          chk("wr_data", oWDATA, iDATA);
          wr_bank[k] = oBANK;
          wr_addr[k] = oADDR;
          ram[0][oBANK][oADDR] = oWDATA;
          acc.push_back(iDATA);
          if (acc.size() == N) start_due = 1;
        end
      end
      if (core_busy) chk("owner_core", oOWNER, 1);
      if (oOWNER == 2'd2) chk("rd_set_held", oRD_SET, rd_sel_exp);
      if (prev_stall) begin
        chk("stall_valid", oVALID, 1);
        chk("stall_data", oDATA, prev_dat);
      end
      if (oVALID && iREADY) begin
        if (n_out >= N) begin
          chk("extra_output", n_out, N - 1);
        end else begin
          chk("out_data", oDATA, exp_out[n_out]);
          chk("out_last", oLAST, n_out == N - 1);
        end
        n_out++;
        if (n_out == N) done_due = 1;
      end
      prev_stall = oVALID && !iREADY;
      prev_dat   = oDATA;
    end
  end

  // RAM read port: one cycle of latency
  always @(posedge iCLK) begin
    #1 iRDATA = rd_next;
  end

  // Downstream ready
  initial begin
    iREADY = 1'b1;
    forever begin
      @(posedge iCLK);
      #1 iREADY = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Core model: stays "ready" 3 cycles after start, runs a few cycles,
  // writes its result into the chosen set, then reports ready.
  initial begin
    iCORE_RDY   = 1'b1;
    iRESULT_SEL = 1'b0;
    core_busy   = 0;
    forever begin
      @(negedge iCLK);
      if (oSTART && !iRESET) begin
        core_busy = 1;
        @(posedge iCLK);
        repeat (3) @(posedge iCLK);
        #1 iCORE_RDY = 1'b0;
        repeat ($urandom_range(2, 5)) @(posedge iCLK);
        @(negedge iCLK);
        if (acc.size() != N) chk("core_input_count", acc.size(), N);
        for (int p = 0; p < N; p++)
          ram[frame_sel][p % 4][p / 4] = xform(frame_sel, ram[0][p % 4][p / 4]);
        for (int j = 0; j < N; j++)
          exp_out[j] = xform(frame_sel, acc[perm(j)]);
        @(posedge iCLK);
        #1;
        iRESULT_SEL = frame_sel;
        rd_sel_exp  = frame_sel;
        iCORE_RDY   = 1'b1;
        @(posedge iCLK);
        #1 core_busy = 0;
        if (tgl_sel) begin
          for (int c = 0; c < 300 && oBUSY; c++) begin
            iRESULT_SEL = 1'($urandom_range(0, 1));
            @(posedge iCLK);
            #1;
          end
          iRESULT_SEL = 1'b0;
        end
      end
    end
  end

  task automatic run_frame(input bit gaps, input bit sel, input bit rr, input bit tg, input int n_load);
    int  guard;
    bit  seen;
    frame_sel = sel;
    rdy_rand  = rr;
    tgl_sel   = tg;
    guard     = 0;
    while (acc.size() < n_load && guard < 500) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        iVALID = 1'b0;
      end else begin
        iVALID = 1'b1;
        iDATA  = 16'($urandom);
      end
      @(posedge iCLK);
      #1;
      guard++;
    end
    iVALID = 1'b0;
    if (guard >= 500) chk("load_timeout", acc.size(), n_load);
    if (n_load < N) begin
      // Abandon the frame with a reset mid-load
      iRESET = 1'b1;
      @(posedge iCLK);
      #1 iRESET = 1'b0;
      @(negedge iCLK);
      chk("midrst_owner", oOWNER, 3);
      chk("midrst_ready", oREADY, 0);
      chk("midrst_busy", oBUSY, 0);
      @(posedge iCLK);
      #1;
      return;
    end
    seen  = 0;
    guard = 0;
    while (!seen && guard < 3000) begin
      // Samples offered outside LOAD must be ignored
      iVALID = core_busy ? 1'($urandom_range(0, 1)) : 1'b0;
      iDATA  = 16'($urandom);
      @(negedge iCLK);
      if (oDONE) seen = 1;
      @(posedge iCLK);
      #1;
      guard++;
    end
    iVALID = 1'b0;
    if (!seen) chk("frame_timeout", guard, 0);
    else chk("frame_out_count", last_count, N);
  endtask

  initial begin
    for (int s = 0; s < 2; s++)
      for (int b = 0; b < 4; b++)
        for (int a = 0; a < 4; a++) ram[s][b][a] = 16'h0;
    iRESET = 1'b1;
    iVALID = 1'b0;
    iDATA  = '0;
    chk_en = 0;
    rdy_rand = 0;
    tgl_sel  = 0;
    frame_sel = 0;
    rd_sel_exp = 0;
    last_count = 0;
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    chk("rst_owner", oOWNER, 3);
    chk("rst_ready", oREADY, 0);
    chk("rst_busy", oBUSY, 0);
    chk("rst_valid", oVALID, 0);
    chk("rst_start", oSTART, 0);
    chk("rst_done", oDONE, 0);
    chk("rst_we", oWE, 0);
    chk("rst_rdset", oRD_SET, 0);
    chk("rst_data", oDATA, 0);
    chk("rst_last", oLAST, 0);
    @(posedge iCLK);
    #1 iRESET = 1'b0;
    chk_en = 1;

    // Continuous load, full-rate unload, result in set A
    run_frame(0, 0, 0, 0, N);
`ifdef FHT_SCHED_BITREV_EN
    chk("k1_bank", wr_bank[1], 0);
    chk("k1_addr", wr_addr[1], 2);
    chk("k5_bank", wr_bank[5], 2);
    chk("k5_addr", wr_addr[5], 2);
`else
    chk("k1_bank", wr_bank[1], 1);
    chk("k1_addr", wr_addr[1], 0);
    chk("k4_bank", wr_bank[4], 0);
    chk("k4_addr", wr_addr[4], 1);
`endif
    // Gapped load, random downstream stalls, set B with iRESULT_SEL toggling
    run_frame(1, 1, 1, 1, N);
    // Reset after 7 accepted samples, then a clean frame from k=0
    run_frame(1, 0, 1, 0, 7);
    run_frame(0, 0, 1, 0, N);
    for (int f = 0; f < 4; f++)
      run_frame(1, 1'($urandom_range(0, 1)), 1, 1, N);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fht_frame_sched.md
# fht_frame_sched

Frame scheduler for the FHT engine. Owns the shared four-bank working RAM and time-multiplexes it between three users:
- an input stream loader;
- the transform core (sequenced by its own stage controller through start/ready);
- an output stream unloader.

Runs one frame at a time (load → transform → unload) and gives the RAM mux exactly one owner per cycle.

## Interface
Parameters:
- A_BIT, 8, bank address width; frame length N = 4·2^A_BIT points
- D_BIT, 16, sample width

Ports:
- iCLK  in  1  clock
- iRESET  in  1  synchronous, active-high reset
- iVALID  in  1  input sample valid
- iDATA  in  D_BIT  input sample
- oREADY  out  1  loader accepts sample (high only in LOAD)
- oSTART  out  1  one-cycle start pulse to core
- iCORE_RDY  in  1  core ready/idle flag
- iRESULT_SEL  in  1  bank set holding the final result (0 = A, 1 = B), sampled when the core finishes
- oOWNER  out  2  RAM mux select: 0 loader, 1 core, 2 unloader, 3 none
- oBANK  out  2  bank index for loader/unloader access
- oADDR  out  A_BIT  in-bank address for loader/unloader access
- oWE  out  1  loader write strobe (bank set A)
- oWDATA  out  D_BIT  loader write data
- oRD_SET  out  1  bank set read by unloader (latched iRESULT_SEL)
- iRDATA  in  D_BIT  RAM read data, 1-cycle latency
- oVALID  out  1  output sample valid
- oDATA  out  D_BIT  output sample
- oLAST  out  1  with oVALID on sample N-1
- iREADY  in  1  downstream accepts sample
- oBUSY  out  1  state ≠ IDLE
- oDONE  out  1  one-cycle pulse after last sample accepted

## Operation
- States:
  - IDLE: oOWNER=3; on iVALID go to LOAD same cycle, without accepting.
  - LOAD: oOWNER=0, oREADY=1. Each iVALID accepts a sample at index k (0..N-1): oBANK=k[1:0], oADDR=k[A_BIT+1:2], oWE=iVALID, oWDATA=iDATA. Accepting k=N-1 → KICK.
  - KICK: oOWNER=1, oSTART=1 for exactly one cycle → ARM.
  - ARM: wait for iCORE_RDY=0 (core has started); then → RUN.
  - RUN: wait for iCORE_RDY=1; latch iRESULT_SEL into oRD_SET → UNLOAD.
  - UNLOAD: oOWNER=2. Read index j uses the same bank/addr mapping as LOAD. Reads are issued only when the 2-entry output skid buffer has a free slot, counting the read in flight. The buffer presents oVALID/oDATA, and a sample is accepted on oVALID&iREADY. oLAST marks j=N-1. After the last read is issued → DRAIN.
  - DRAIN: oOWNER=2 until the buffer empties; then pulse oDONE → IDLE.
- Counters k and j are A_BIT+2 bits and clear on entering LOAD or UNLOAD. No wrap: the terminal index ends the phase.
- oVALID must not depend combinationally on iREADY. oDATA stays stable while oVALID&!iREADY.
- iVALID outside LOAD is ignored, and no samples are lost because oREADY=0.
- Reset: state IDLE, counters 0, skid buffer empty. All outputs 0 except oOWNER=3. Reset mid-frame abandons the frame; the core is not signalled.

## Timing
- Loader: write lands in the same cycle as acceptance (oWE combinational on iVALID in LOAD); full throughput of 1 sample/cycle.
- KICK follows the last accepted sample by 1 cycle. oSTART is high exactly 1 cycle.
- ARM tolerates iCORE_RDY staying high for any number of cycles after oSTART.
- Unloader:
  - First oVALID appears 2 cycles after entering UNLOAD: read issue plus RAM latency.
  - Sustains 1 sample/cycle while iREADY=1.
  - With iREADY=0, at most 2 samples are buffered and no read is issued.
- oDONE is asserted the cycle after the N-th output handshake. IDLE→LOAD can occur the following cycle.
- Frame latency ≈ N (load) + core time + N + 2 cycles.

## Configuration
- FHT_SCHED_BITREV_EN:
  - Defined: the loader writes sample k at position bitrev(k) over A_BIT+2 bits, with bank/addr split as above. The core then receives bit-reversed input.
  - Undefined: natural order.
- The unloader is always natural order.

## Structure
- Shared package or fht_defines: state encoding constants (IDLE, LOAD, KICK, ARM, RUN, UNLOAD, DRAIN), owner codes (LOADER=0, CORE=1, UNLOADER=2, NONE=3), and a bit-reverse function parameterised on width.
- One sub-module: fht_out_skid, a 2-entry valid/ready skid buffer with D_BIT+1 data (sample plus last flag) and a free-slot output used to gate read issue.

## Test plan
- A_BIT=2 (N=16), natural order, continuous 16-sample load with iREADY=1. Expect:
  - oWE at banks 0,1,2,3,0… and addr 0,0,0,0,1…;
  - oSTART 1 cycle after the 16th sample;
  - after the core model's ready rises, 16 outputs with oLAST on the 16th, then oDONE.
- Core model holds iCORE_RDY high for 3 cycles after oSTART before dropping. Expect the scheduler to stay in ARM, issue no second oSTART, and keep oOWNER=1 until the rise.
- Random iREADY (50%) during unload. Expect no sample dropped or duplicated, oDATA stable while stalled, and never more than 2 reads outstanding beyond acceptances.
- iRESULT_SEL=1 at core finish, then toggled during unload. Expect oRD_SET=1 throughout the unload.
- FHT_SCHED_BITREV_EN defined, N=16, sample k=1. Expect the write to bitrev(1)=8: bank 0, addr 2.
- iRESET asserted mid-LOAD at k=7. Expect next cycle IDLE, oOWNER=3, oREADY=0; a new frame then loads from k=0.
